// File: rtl/dom_rand_pkg.sv
// Shared definitions for the DOM fresh-randomness source.
// Contents: LFSR width and tap mask, FSM state type, single-step LFSR function.
package dom_rand_pkg;

    localparam int unsigned LFSR_W    = 32;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003; // x^32+x^22+x^2+x+1

    typedef enum logic [1:0] {
        UNSEEDED  = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2
    } rand_state_t;

    // One right-shift Galois step: shifted-out bit folds the taps back in.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

endpackage

// File: rtl/dom_rand_gen_lfsr_multistep.sv
// Combinational multi-step LFSR advance.
// Ports:
//   state      in  32  current LFSR state
//   next_state out 32  state after STEPS Galois steps
module lfsr_multistep
    import dom_rand_pkg::*;
#(
    parameter int unsigned STEPS = 5
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next_state
);

    always_comb begin
        next_state = state;
        for (int unsigned i = 0; i < STEPS; i++) begin
            next_state = lfsr_step(next_state);
        end
    end

endmodule

// File: rtl/dom_rand_gen.sv
// Fresh-randomness source for a first-order DOM masked S-box.
// A seeded 32-bit Galois LFSR advances WIDTH_Z steps per accepted draw; the
// low WIDTH_Z bits feed the gadgets' z0 inputs. Use is blocked until seeded
// and again after RESEED_INTERVAL draws until a new nonzero seed arrives.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   seed_valid  in   seed offered
//   seed_ready  out  always 1
//   seed_data   in   32-bit new LFSR state (zero is rejected)
//   seed_err    out  one-cycle pulse after a zero seed was rejected
//   z_req       in   consumer takes z_out this cycle
//   z_valid     out  z_out fresh and unused
//   z_out       out  WIDTH_Z resharing bits
//   reseed_req  out  high while unseeded or exhausted
module dom_rand_gen
    import dom_rand_pkg::*;
#(
    parameter int unsigned WIDTH_Z         = 5,
    parameter int unsigned RESEED_INTERVAL = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_valid,
    output logic               seed_ready,
    input  logic [31:0]        seed_data,
    output logic               seed_err,
    input  logic               z_req,
    output logic               z_valid,
    output logic [WIDTH_Z-1:0] z_out,
    output logic               reseed_req
);

    localparam int unsigned CNT_W = $clog2(RESEED_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_INTERVAL);

    logic [LFSR_W-1:0] state_q, state_d, state_adv;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rand_state_t       fsm_q, fsm_d;
    logic              seed_err_q, seed_err_d;
    logic              z_valid_q, reseed_req_q;
    logic              seed_ok, seed_zero, draw;

    lfsr_multistep #(
        .STEPS (WIDTH_Z)
    ) u_multistep (
        .state      (state_q),
        .next_state (state_adv)
    );

    assign seed_ready = 1'b1;
    assign seed_ok    = seed_valid && (seed_data != '0);
    assign seed_zero  = seed_valid && (seed_data == '0);
    assign draw       = z_req && z_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fsm_d      = fsm_q;
        seed_err_d = seed_zero;
        // A valid seed overrides a coincident draw: the consumed bits are
        // discarded along with the old state.
        if (seed_ok) begin
            state_d = seed_data;
            cnt_d   = '0;
            fsm_d   = RUN;
        end else if (draw) begin
            state_d = state_adv;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CNT_MAX) begin
                fsm_d = EXHAUSTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '0;
            cnt_q        <= '0;
            fsm_q        <= UNSEEDED;
            seed_err_q   <= 1'b0;
            z_valid_q    <= 1'b0;
            reseed_req_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fsm_q        <= fsm_d;
            seed_err_q   <= seed_err_d;
            // Decoded from the next state so the outputs come straight off flops.
            z_valid_q    <= (fsm_d == RUN);
            reseed_req_q <= (fsm_d != RUN);
        end
    end

    assign seed_err   = seed_err_q;
    assign z_valid    = z_valid_q;
    assign reseed_req = reseed_req_q;
    assign z_out      = state_q[WIDTH_Z-1:0];

endmodule

// File: tb/tb_dom_rand_gen.sv
// Directed self-checking bench for dom_rand_gen (WIDTH_Z=5, RESEED_INTERVAL=4).
module tb_dom_rand_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed_data;
    logic        seed_err;
    logic        z_req;
    logic        z_valid;
    logic [4:0]  z_out;
    logic        reseed_req;

    int n_cmp = 0;
    int n_bad = 0;

    dom_rand_gen #(
        .WIDTH_Z         (5),
        .RESEED_INTERVAL (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .seed_err   (seed_err),
        .z_req      (z_req),
        .z_valid    (z_valid),
        .z_out      (z_out),
        .reseed_req (reseed_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int draws;

    initial begin
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed_data  = '0;
        z_req      = 1'b0;
        #2;
        check("rst_z_valid", 32'(z_valid), 0);
        check("rst_reseed_req", 32'(reseed_req), 1);
        check("rst_z_out", 32'(z_out), 0);
        check("rst_seed_err", 32'(seed_err), 0);
        check("rst_seed_ready", 32'(seed_ready), 1);
        step();
        rst = 1'b0;

        // Requests before seeding are ignored.
        z_req = 1'b1;
        repeat (5) step();
        check("unseeded_z_valid", 32'(z_valid), 0);
        check("unseeded_reseed_req", 32'(reseed_req), 1);
        check("unseeded_state", dut.state_q, 32'h0);
        z_req = 1'b0;

        // Zero seed is rejected.
        seed_valid = 1'b1;
        seed_data  = 32'h0;
        step();
        seed_valid = 1'b0;
        check("zero_seed_err", 32'(seed_err), 1);
        check("zero_seed_z_valid", 32'(z_valid), 0);
        step();
        check("zero_seed_err_drop", 32'(seed_err), 0);
        check("zero_seed_reseed_req", 32'(reseed_req), 1);

        // First seed and draws.
        seed_valid = 1'b1;
        seed_data  = 32'h00000001;
        step();
        seed_valid = 1'b0;
        check("seed1_z_valid", 32'(z_valid), 1);
        check("seed1_z_out", 32'(z_out), 32'h01);
        check("seed1_reseed_req", 32'(reseed_req), 0);
        repeat (3) step();
        check("stable_z_out", 32'(z_out), 32'h01);
        z_req = 1'b1;
        step();
        check("draw1_state", dut.state_q, 32'hD8360002);
        check("draw1_z_out", 32'(z_out), 32'h02);
        step();
        check("draw2_state", dut.state_q, 32'hB6EDB003);
        check("draw2_z_out", 32'(z_out), 32'h03);

        // Draw with a coincident zero seed: draw proceeds, error pulses.
        seed_valid = 1'b1;
        seed_data  = 32'h0;
        step();
        seed_valid = 1'b0;
        z_req      = 1'b0;
        check("drawzero_seed_err", 32'(seed_err), 1);
        check("drawzero_state", dut.state_q, 32'h6DAD6D81);
        check("drawzero_z_out", 32'(z_out), 32'h01);
        check("drawzero_cnt", 32'(dut.cnt_q), 3);
        check("drawzero_z_valid", 32'(z_valid), 1);

        // Draw and valid seed together: seed wins.
        z_req      = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 32'hCAFEBABE;
        step();
        seed_valid = 1'b0;
        check("drawseed_state", dut.state_q, 32'hCAFEBABE);
        check("drawseed_cnt", 32'(dut.cnt_q), 0);
        check("drawseed_z_out", 32'(z_out), 32'h1E);

        // Exhaustion under continuous requests.
        draws = 0;
        for (int i = 0; i < 10; i++) begin
            if (z_valid && z_req) draws++;
            step();
        end
        check("exhaust_draws", 32'(draws), 4);
        check("exhaust_z_valid", 32'(z_valid), 0);
        check("exhaust_reseed_req", 32'(reseed_req), 1);
        check("exhaust_cnt_sat", 32'(dut.cnt_q), 4);

        // Reseed from exhaustion.
        z_req      = 1'b0;
        seed_valid = 1'b1;
        seed_data  = 32'h12345678;
        step();
        seed_valid = 1'b0;
        check("reseed_z_out", 32'(z_out), 32'h18);
        check("reseed_z_valid", 32'(z_valid), 1);
        check("reseed_reseed_req", 32'(reseed_req), 0);

        // Asynchronous reset between edges during a draw stream.
        z_req = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_z_valid", 32'(z_valid), 0);
        check("async_z_out", 32'(z_out), 0);
        check("async_reseed_req", 32'(reseed_req), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_z_valid", 32'(z_valid), 0);
        check("post_rst_state", dut.state_q, 32'h0);
        z_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dom_rand_gen.md
# dom_rand_gen

Fresh-randomness source for the first-order masked (DOM) Ascon S-box datapath. Produces a `WIDTH_Z`-bit vector of resharing bits per cycle, one bit per DOM AND gadget's `z0` input, from a seeded 32-bit Galois LFSR. Sits directly upstream of the gadgets. Enforces seeding before use and a reseed after `RESEED_INTERVAL` draws, so gadgets never consume stale or all-zero randomness.

## Interface
Parameters:
- `WIDTH_Z`, default 5: resharing bits per draw, one per DOM AND in the χ layer; legal range 1..32.
- `RESEED_INTERVAL`, default 1024: accepted draws allowed per seed; must be ≥1.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `seed_valid`  in  1  — seed offered.
- `seed_ready`  out  1  — seed can be taken; constant 1 out of reset.
- `seed_data`  in  32  — new LFSR state.
- `seed_err`  out  1  — one-cycle pulse: all-zero seed was rejected.
- `z_req`  in  1  — consumer takes `z_out` this cycle.
- `z_valid`  out  1  — `z_out` is fresh and unused.
- `z_out`  out  `WIDTH_Z`  — resharing bits, equal to `state[WIDTH_Z-1:0]`.
- `reseed_req`  out  1  — high in UNSEEDED and EXHAUSTED.

## Operation
- **LFSR:** 32-bit right-shift Galois, polynomial x^32+x^22+x^2+x+1, tap mask `0x80200003`.
  - One step: `lsb = s[0]`; `s = s >> 1`; if `lsb`, `s ^= 0x80200003`.
  - A draw advances the state by exactly `WIDTH_Z` steps, unrolled combinationally, in one cycle.
- **FSM states:** UNSEEDED, RUN, EXHAUSTED.
  - UNSEEDED → RUN on a seed handshake with nonzero `seed_data`.
  - RUN → EXHAUSTED when a draw brings the draw counter to `RESEED_INTERVAL`.
  - EXHAUSTED → RUN on a nonzero seed handshake.
  - RUN → RUN on a nonzero seed handshake (early reseed): state is loaded and the counter cleared.
- **Seed handshake:** `seed_valid && seed_ready`.
  - Nonzero seed: state ← `seed_data`, counter ← 0.
  - All-zero seed: state and FSM unchanged, `seed_err` pulses the next cycle.
- **Draw:** `z_req && z_valid`. State advances `WIDTH_Z` steps and the counter increments.
  - `z_req` while `z_valid`=0 is ignored. No state change, no count.
- `z_valid` = 1 only in RUN.
- **Stability:** `z_out` is stable while `z_valid && !z_req`.
- **Counter:** width `$clog2(RESEED_INTERVAL+1)`; saturates, never wraps.
- **Draw and seed in the same cycle:** the draw is counted as consumed by the gadget, but the seed wins. Next state = seed, counter = 0.
- **Draw and zero seed in the same cycle:** the draw proceeds normally and `seed_err` pulses.
- **Last permitted draw:** the draw that makes counter = `RESEED_INTERVAL` is the last one. `z_valid` drops the following cycle.

## Timing
- **Reset values:** state = 0, FSM = UNSEEDED, counter = 0, `z_valid` = 0, `z_out` = 0, `reseed_req` = 1, `seed_err` = 0, `seed_ready` = 1.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous). Randomness is never retained.
- **Seed-to-output latency:** seed accepted at edge N → `z_valid` = 1 and `z_out` = `seed_data[WIDTH_Z-1:0]` after edge N, with `reseed_req` = 0.
- **Throughput:** one draw per cycle under continuous `z_req`. A new `z_out` appears after each draw edge.
- **Gadget-side rule:** `z_out` may feed a gadget's `z0` combinationally. The gadget registers it on the same edge the draw is accepted.
- **Output registering:** `reseed_req` and `z_valid` are registered FSM decodes, glitch-free.

## Structure
- **Package `dom_rand_pkg`:**
  - `LFSR_W` = 32 and `LFSR_TAPS` = `32'h80200003`.
  - FSM enum `rand_state_t` {UNSEEDED, RUN, EXHAUSTED}.
  - Function `lfsr_step(logic [31:0])`.
- **Sub-module `lfsr_multistep`:** combinational, parameterised by step count. Applies `lfsr_step` `WIDTH_Z` times.
- **Top `dom_rand_gen`:** FSM, counter and handshakes.

## Test plan
- **Reset then draw:** reset, then `z_req`=1 for 5 cycles → `z_valid`=0, `reseed_req`=1, state stays 0.
- **First seed and draw (`WIDTH_Z`=5):** seed `0x00000001` → next cycle `z_out`=5'b00001. After one draw, state = `0xD8360002` and `z_out`=5'b00010.
- **Zero seed:** seed `0x00000000` in UNSEEDED → `seed_err` pulses once, FSM stays UNSEEDED, `z_valid`=0.
- **Exhaustion (`RESEED_INTERVAL`=4):** seed, then continuous `z_req`.
  - Exactly 4 draws are accepted, then `z_valid`=0 and `reseed_req`=1.
  - New seed `0x12345678` → `z_out`=5'b11000 next cycle.
- **Simultaneous draw and seed:** draw and seed `0xCAFEBABE` in the same cycle → next state `0xCAFEBABE`, counter 0, `z_out`=5'b11110.
- **Async reset mid-run:** assert `rst` between edges during a draw stream → `z_valid` falls with no clock edge. After release, no output until reseed.
